apb_slave_regs: RTL and testbench
=================================

Name: apb_slave_regs

Overview:
- APB completer (slave) sitting at the far end of the bus driven by our APB master, i.e. the responder to the master interface the bench already drives.
- Holds a small word-addressed register bank, inserts a fixed number of wait states, and flags decode/access errors via pslverr.
- Used as the DUT-side target in master-level benches and as a reusable config-register block in the fabric.

Parameters:
ADDR_WIDTH, 32, paddr width (matches APB_ADDR_WIDTH)
DATA_WIDTH, 32, pwdata/prdata width (matches APB_DATA_WIDTH); multiple of 8
NUM_REGS, 8, register count; legal 2..256
WAIT_CYCLES, 2, wait states inserted in ACCESS phase; legal 0..15
ID_VALUE, 32'hA9B0_0001, constant returned by read-only register 0

Ports:
clk  input  1  bus clock, all logic on rising edge
rst  input  1  synchronous active-high reset
paddr  input  ADDR_WIDTH  byte address
psel  input  1  slave select
penable  input  1  access-phase indicator
pwrite  input  1  1=write, 0=read
pwdata  input  DATA_WIDTH  write data
pready  output  1  transfer complete, registered
prdata  output  DATA_WIDTH  read data, valid only with pready=1, registered
pslverr  output  1  error response, valid only with pready=1, registered

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high (ports clk, rst).
- Reset (rst=1 at a clk edge): state=IDLE, pready=0, pslverr=0, prdata=0, wait counter=0, regs 1..NUM_REGS-1 = 0. Applies mid-transfer: the transfer is abandoned and no write commits.
- Decode: idx = paddr[ADDR_WIDTH-1:2]. Error if paddr[1:0]!=0, idx>=NUM_REGS, or a write to idx 0. Decode is evaluated at the SETUP capture.
- FSM states:
  - IDLE: on psel=1 and penable=0, capture paddr, pwrite, pwdata and the error flag; load cnt=WAIT_CYCLES; go to ACCESS. If WAIT_CYCLES=0, set pready=1 on the same edge. Any other input is ignored.
  - ACCESS: if psel=0, abort: go to IDLE, pready=0, no write (protocol violation tolerated).
    - If pready=0: decrement cnt. When cnt reaches 1 (or starts at 1), set pready=1 on that edge, giving exactly WAIT_CYCLES low-pready cycles with penable=1.
    - If pready=1 and psel=penable=1: complete. Write commits on this edge if no error. Clear pready, pslverr and prdata next edge, and go to IDLE.
- Data and error on the pready-asserting edge:
  - prdata is loaded from the reg (reg 0 returns ID_VALUE) for an error-free read, else 0.
  - pslverr is the captured error flag.
- Errored transfers never modify state. Read of reg 0 is legal.
- Back-to-back: the SETUP of the next transfer falls in the cycle after completion, which is IDLE, so no dead cycle beyond the protocol's.
- Captured pwdata is used, not the live bus; changes to paddr/pwdata during ACCESS have no effect.

Optional Feature:
- Macro APB_WSTRB_EN.
- Defined:
  - Adds port pstrb input DATA_WIDTH/8, captured at SETUP.
  - A write updates only the byte lanes whose strobe bit is 1; pstrb=0 on a valid reg completes with pslverr=0 and no change.
  - pstrb is ignored on reads.
- Undefined: no pstrb port; every write updates the full word.

Test Plan:
- Reset, then read idx 0 (paddr=0x0), WAIT_CYCLES=2 -> pready low for 2 ACCESS cycles, then high 1 cycle; prdata=0xA9B00001, pslverr=0.
- Write 0xDEADBEEF to paddr=0x4, then read 0x4 -> prdata=0xDEADBEEF, pslverr=0 on both; with WAIT_CYCLES=0, pready is high in the first ACCESS cycle.
- Error cases, each -> pslverr=1 with pready, prdata=0, reg contents unchanged on re-read:
  - write to paddr=0x0
  - read paddr=0x20 (NUM_REGS=8)
  - write to paddr=0x6
- Abort: drop psel during the wait of a write 0x12345678 to 0x8 -> pready never asserts, 0x8 still reads 0.
- Reset mid-transfer: assert rst during the ACCESS of a write to 0xC -> pready=0 next cycle, 0xC reads 0 afterwards; previously written 0x4 also reads 0.
- APB_WSTRB_EN: write 0xFFFFFFFF to 0x4 with pstrb=4'b0101 over 0 -> reads 0x00FF00FF; pstrb=0 write leaves the value intact, pslverr=0.

Source files
------------

// File: rtl/apb_slave_regs_if.sv
// APB bus bundle between master and completer (apb_slave_regs).
// Define APB_WSTRB_EN to add the pstrb write-strobe lanes.
interface apb_slave_regs_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   paddr;
  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [DATA_WIDTH-1:0]   pwdata;
`ifdef APB_WSTRB_EN
  logic [DATA_WIDTH/8-1:0] pstrb;
`endif
  logic                    pready;
  logic [DATA_WIDTH-1:0]   prdata;
  logic                    pslverr;

`ifdef APB_WSTRB_EN
  modport master (output paddr, psel, penable, pwrite, pwdata, pstrb,
                  input  pready, prdata, pslverr);
  modport slave  (input  paddr, psel, penable, pwrite, pwdata, pstrb,
                  output pready, prdata, pslverr);
`else
  modport master (output paddr, psel, penable, pwrite, pwdata,
                  input  pready, prdata, pslverr);
  modport slave  (input  paddr, psel, penable, pwrite, pwdata,
                  output pready, prdata, pslverr);
`endif
endinterface

// File: rtl/apb_slave_regs.sv
// APB completer with a word-addressed register bank (reg 0 = read-only ID),
// fixed wait states and pslverr on decode errors. APB_WSTRB_EN enables byte strobes.
module apb_slave_regs #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    NUM_REGS    = 8,
  parameter int                    WAIT_CYCLES = 2,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE    = 32'hA9B0_0001
) (
  input logic              clk,
  input logic              rst,
  apb_slave_regs_if.slave  apb
);
  localparam int IDX_W  = $clog2(NUM_REGS);
  localparam int AIDX_W = ADDR_WIDTH - 2;
  localparam int NB     = DATA_WIDTH / 8;

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  state_t                r_state, w_state_next;
  logic [3:0]            r_cnt, w_cnt_next;
  logic                  r_pready, w_pready_next;
  logic                  r_pslverr, w_pslverr_next;
  logic [DATA_WIDTH-1:0] r_prdata, w_prdata_next;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_write;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  w_capture;
  logic                  w_commit;
  logic [AIDX_W-1:0]     w_live_aidx;
  logic [IDX_W-1:0]      w_live_idx;
  logic                  w_live_err;
  logic [DATA_WIDTH-1:0] w_regs [NUM_REGS];
  logic [DATA_WIDTH-1:0] w_wmask;

  // Decode on the live bus; only meaningful at the SETUP capture.
  assign w_live_aidx = apb.paddr[ADDR_WIDTH-1:2];
  assign w_live_idx  = w_live_aidx[IDX_W-1:0];
  assign w_live_err  = (apb.paddr[1:0] != 2'b00) ||
                       (w_live_aidx >= AIDX_W'(NUM_REGS)) ||
                       (apb.pwrite && (w_live_aidx == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_prdata  <= '0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_pready  <= w_pready_next;
      r_pslverr <= w_pslverr_next;
      r_prdata  <= w_prdata_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_pready_next  = r_pready;
    w_pslverr_next = r_pslverr;
    w_prdata_next  = r_prdata;
    w_capture      = 1'b0;
    w_commit       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (apb.psel && !apb.penable) begin
          w_capture    = 1'b1;
          w_cnt_next   = 4'(WAIT_CYCLES);
          w_state_next = S_ACCESS;
          // Zero wait states: respond from the live SETUP values on the same edge.
          if (WAIT_CYCLES == 0) begin
            w_pready_next  = 1'b1;
            w_pslverr_next = w_live_err;
            w_prdata_next  = (!apb.pwrite && !w_live_err) ? w_regs[w_live_idx] : '0;
          end
        end
      end
      S_ACCESS: begin
        if (!apb.psel) begin
          w_state_next   = S_IDLE;
          w_pready_next  = 1'b0;
          w_pslverr_next = 1'b0;
          w_prdata_next  = '0;
        end else if (!r_pready) begin
          w_cnt_next = r_cnt - 4'd1;
          if (r_cnt <= 4'd1) begin
            w_pready_next  = 1'b1;
            w_pslverr_next = r_err;
            w_prdata_next  = (!r_write && !r_err) ? w_regs[r_idx] : '0;
          end
        end else if (apb.penable) begin
          w_commit       = r_write && !r_err;
          w_state_next   = S_IDLE;
          w_pready_next  = 1'b0;
          w_pslverr_next = 1'b0;
          w_prdata_next  = '0;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx   <= '0;
      r_write <= 1'b0;
      r_err   <= 1'b0;
      r_wdata <= '0;
    end else if (w_capture) begin
      r_idx   <= w_live_idx;
      r_write <= apb.pwrite;
      r_err   <= w_live_err;
      r_wdata <= apb.pwdata;
    end
  end

  genvar gi;
`ifdef APB_WSTRB_EN
  logic [NB-1:0] r_strb;
  always_ff @(posedge clk) begin
    if (rst)            r_strb <= '0;
    else if (w_capture) r_strb <= apb.pstrb;
  end
  for (gi = 0; gi < NB; gi++) begin : g_lane
    assign w_wmask[gi*8 +: 8] = {8{r_strb[gi]}};
  end
`else
  assign w_wmask = '1;
`endif

  for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    if (gi == 0) begin : g_id
      assign w_regs[gi] = ID_VALUE;
    end else begin : g_rw
      logic [DATA_WIDTH-1:0] r_value;
      always_ff @(posedge clk) begin
        if (rst)
          r_value <= '0;
        else if (w_commit && (r_idx == IDX_W'(gi)))
          r_value <= (r_value & ~w_wmask) | (r_wdata & w_wmask);
      end
      assign w_regs[gi] = r_value;
    end
  end

  assign apb.pready  = r_pready;
  assign apb.pslverr = r_pslverr;
  assign apb.prdata  = r_prdata;
endmodule

// File: tb/tb_apb_slave_regs.sv
// Directed bench for apb_slave_regs: vector table on a 2-wait-state instance,
// hand sequences for zero-wait, abort, mid-transfer reset and (APB_WSTRB_EN) strobes.
module tb_apb_slave_regs;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] m_paddr, m_pwdata;
  logic        m_psel, m_penable, m_pwrite;
  logic [3:0]  m_strb;
  bit          m_tgt;
  int          total = 0;
  int          bad   = 0;

  apb_slave_regs_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus0 ();
  apb_slave_regs_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus1 ();

  assign bus0.paddr   = m_paddr;
  assign bus0.psel    = m_psel && !m_tgt;
  assign bus0.penable = m_penable;
  assign bus0.pwrite  = m_pwrite;
  assign bus0.pwdata  = m_pwdata;
  assign bus1.paddr   = m_paddr;
  assign bus1.psel    = m_psel && m_tgt;
  assign bus1.penable = m_penable;
  assign bus1.pwrite  = m_pwrite;
  assign bus1.pwdata  = m_pwdata;
`ifdef APB_WSTRB_EN
  assign bus0.pstrb   = m_strb;
  assign bus1.pstrb   = m_strb;
`endif

  apb_slave_regs #(.WAIT_CYCLES(2)) u_dut0 (.clk(clk), .rst(rst), .apb(bus0));
  apb_slave_regs #(.WAIT_CYCLES(0)) u_dut1 (.clk(clk), .rst(rst), .apb(bus1));

  function automatic logic cur_pready();
    return m_tgt ? bus1.pready : bus0.pready;
  endfunction
  function automatic logic cur_pslverr();
    return m_tgt ? bus1.pslverr : bus0.pslverr;
  endfunction
  function automatic logic [31:0] cur_prdata();
    return m_tgt ? bus1.prdata : bus0.prdata;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One full APB transfer; bus address/data are scrambled during ACCESS to
  // prove the completer uses its SETUP capture.
  task automatic xfer(input bit tgt, input bit wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] strb,
                      output logic [31:0] rdata, output logic err, output int waits);
    m_tgt = tgt;
    @(posedge clk); #1;
    m_paddr = addr; m_pwrite = wr; m_pwdata = wdata; m_strb = strb;
    m_psel = 1'b1; m_penable = 1'b0;
    @(posedge clk); #1;
    m_penable = 1'b1;
    m_paddr   = addr ^ 32'h4;
    m_pwdata  = ~wdata;
    waits = 0;
    while (!cur_pready() && waits < 40) begin
      @(posedge clk); #1;
      waits++;
    end
    rdata = cur_prdata();
    err   = cur_pslverr();
    if (!cur_pready()) begin
      total++; bad++;
      $display("FAIL pready_timeout: got 0 after %0d cycles, expected 1", waits);
    end
    @(posedge clk); #1;
    m_psel = 1'b0; m_penable = 1'b0;
    check("pready_after_done", 32'(cur_pready()), 32'd0);
    $display("xfer dut=%0d wr=%0d addr=%h wdata=%h strb=%b rdata=%h err=%0d waits=%0d",
             tgt, wr, addr, wdata, strb, rdata, err, waits);
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  vec_t        vecs [12];
  logic [31:0] rd;
  logic        er;
  int          w;

  initial begin
    vecs[0]  = '{1'b0, 32'h00, 32'h0,         32'hA9B00001, 1'b0};
    vecs[1]  = '{1'b1, 32'h04, 32'hDEADBEEF,  32'h0,        1'b0};
    vecs[2]  = '{1'b0, 32'h04, 32'h0,         32'hDEADBEEF, 1'b0};
    vecs[3]  = '{1'b1, 32'h00, 32'h11111111,  32'h0,        1'b1};
    vecs[4]  = '{1'b0, 32'h00, 32'h0,         32'hA9B00001, 1'b0};
    vecs[5]  = '{1'b0, 32'h20, 32'h0,         32'h0,        1'b1};
    vecs[6]  = '{1'b1, 32'h06, 32'h55555555,  32'h0,        1'b1};
    vecs[7]  = '{1'b0, 32'h04, 32'h0,         32'hDEADBEEF, 1'b0};
    vecs[8]  = '{1'b1, 32'h1C, 32'h0BADF00D,  32'h0,        1'b0};
    vecs[9]  = '{1'b0, 32'h1C, 32'h0,         32'h0BADF00D, 1'b0};
    vecs[10] = '{1'b0, 32'h18, 32'h0,         32'h0,        1'b0};
    vecs[11] = '{1'b0, 32'h02, 32'h0,         32'h0,        1'b1};

    rst = 1'b1;
    m_paddr = '0; m_pwdata = '0; m_psel = 1'b0; m_penable = 1'b0;
    m_pwrite = 1'b0; m_strb = 4'hF; m_tgt = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_pready0",  32'(bus0.pready),  32'd0);
    check("reset_pslverr0", 32'(bus0.pslverr), 32'd0);
    check("reset_prdata0",  bus0.prdata,       32'd0);
    check("reset_pready1",  32'(bus1.pready),  32'd0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      xfer(1'b0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, 4'hF, rd, er, w);
      check($sformatf("vec%0d_prdata", i),  rd,      vecs[i].exp_rdata);
      check($sformatf("vec%0d_pslverr", i), 32'(er), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d_waits", i),   32'(w),  32'd2);
    end

    // Zero-wait instance: pready already high in the first ACCESS cycle.
    xfer(1'b1, 1'b1, 32'h04, 32'hDEADBEEF, 4'hF, rd, er, w);
    check("nowait_wr_waits",   32'(w),  32'd0);
    check("nowait_wr_pslverr", 32'(er), 32'd0);
    xfer(1'b1, 1'b0, 32'h04, 32'h0, 4'hF, rd, er, w);
    check("nowait_rd_waits",   32'(w),  32'd0);
    check("nowait_rd_prdata",  rd,      32'hDEADBEEF);
    check("nowait_rd_pslverr", 32'(er), 32'd0);
    xfer(1'b1, 1'b0, 32'h20, 32'h0, 4'hF, rd, er, w);
    check("nowait_err_pslverr", 32'(er), 32'd1);
    check("nowait_err_prdata",  rd,      32'd0);

    // Abort: drop psel during the wait of a write to 0x8.
    m_tgt = 1'b0;
    @(posedge clk); #1;
    m_paddr = 32'h08; m_pwrite = 1'b1; m_pwdata = 32'h12345678;
    m_psel = 1'b1; m_penable = 1'b0;
    @(posedge clk); #1;
    m_penable = 1'b1;
    @(posedge clk); #1;
    check("abort_wait_pready", 32'(bus0.pready), 32'd0);
    m_psel = 1'b0; m_penable = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check($sformatf("abort_idle%0d_pready", c), 32'(bus0.pready), 32'd0);
    end
    $display("abort dut=0 addr=00000008 wdata=12345678");
    xfer(1'b0, 1'b0, 32'h08, 32'h0, 4'hF, rd, er, w);
    check("abort_readback", rd, 32'd0);

    // Reset during ACCESS of a write to 0xC.
    @(posedge clk); #1;
    m_paddr = 32'h0C; m_pwrite = 1'b1; m_pwdata = 32'hCAFEF00D;
    m_psel = 1'b1; m_penable = 1'b0;
    @(posedge clk); #1;
    m_penable = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_pready", 32'(bus0.pready), 32'd0);
    rst = 1'b0; m_psel = 1'b0; m_penable = 1'b0;
    $display("reset dut=0 during write addr=0000000c");
    xfer(1'b0, 1'b0, 32'h0C, 32'h0, 4'hF, rd, er, w);
    check("midrst_read_c", rd, 32'd0);
    xfer(1'b0, 1'b0, 32'h04, 32'h0, 4'hF, rd, er, w);
    check("midrst_read_4", rd, 32'd0);

`ifdef APB_WSTRB_EN
    xfer(1'b0, 1'b1, 32'h04, 32'hFFFFFFFF, 4'b0101, rd, er, w);
    check("strb_wr_pslverr", 32'(er), 32'd0);
    xfer(1'b0, 1'b0, 32'h04, 32'h0, 4'b0000, rd, er, w);
    check("strb_read", rd, 32'h00FF00FF);
    xfer(1'b0, 1'b1, 32'h04, 32'h12345678, 4'b0000, rd, er, w);
    check("strb0_pslverr", 32'(er), 32'd0);
    xfer(1'b0, 1'b0, 32'h04, 32'h0, 4'b0000, rd, er, w);
    check("strb0_read", rd, 32'h00FF00FF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
